// File: rtl/west_edge_feeder.sv
// West-edge feeder for the systolic MAC array.
// Accepts one command at a time and issues a 3-bit instruction word and a
// bw-bit activation to each row. Row r lags row 0 by r cycles. inst bit 2
// is the OS select, bit 1 is execute, and bit 0 is kernel-load (WS) or
// flush (OS).
module west_edge_feeder #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int len_bw = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_os,
    input  logic [len_bw-1:0]     cmd_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [row*bw-1:0]     data_in,
    output logic [row*3-1:0]      inst_w,
    output logic [row*bw-1:0]     in_w,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (row > 1) ? $clog2(row) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_EXEC  = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                os_q, os_d;
    logic [len_bw-1:0]   len_q, len_d;
    logic [len_bw-1:0]   cnt_q, cnt_d;
    logic [len_bw-1:0]   cnt_inc;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic                issue;
    logic [2:0]          inst0_d;
    logic [row*bw-1:0]   vec0_d;

    assign cnt_inc = cnt_q + len_bw'(1);

    // Next-state logic, handshakes and the row-0 stage contents.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        os_d       = os_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        inst0_d    = {os_q, 2'b00};
        vec0_d     = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    os_d    = cmd_os;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    // The new OS select reaches row 0 right away so the
                    // tiles see it before the first real operation.
                    inst0_d = {cmd_os, 2'b00};
                    if (cmd_len == '0 || cmd_op == OP_RSVD) begin
                        // Nothing to issue: the drain counter is preset so
                        // done pulses in the very next cycle.
                        state_d = DRAIN;
                        dcnt_d  = CW'(row - 1);
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (op_q == OP_FLUSH) begin
                    inst0_d = {os_q, 2'b01};
                    issue   = 1'b1;
                end else begin
                    data_ready = data_valid;
                    if (data_valid) begin
                        inst0_d = {os_q, op_q == OP_EXEC, op_q == OP_LOAD};
                        vec0_d  = data_in;
                        issue   = 1'b1;
                    end
                end
                if (issue) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            DRAIN: begin
                // The last op needs row-1 further cycles to reach the bottom row.
                if (dcnt_q == CW'(row - 1)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            os_q    <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            os_q    <= os_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Skew pipeline: stage r carries the instruction together with the
    // slices still needed by rows r and below. Each stage drops the slice
    // it consumes.
    for (genvar r = 0; r < row; r++) begin : g_stage
        logic [2:0]              inst_q;
        logic [(row-r)*bw-1:0]   vec_q;

        if (r == 0) begin : g_head
            // Row-0 stage loads the instruction chosen for this cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    inst_q <= '0;
                    vec_q  <= '0;
                end else begin
                    inst_q <= inst0_d;
                    vec_q  <= vec0_d;
                end
            end
        end else begin : g_tail
            // Row r copies row r-1 from the previous cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    inst_q <= '0;
                    vec_q  <= '0;
                end else begin
                    inst_q <= g_stage[r-1].inst_q;
                    vec_q  <= g_stage[r-1].vec_q[(row-r+1)*bw-1:bw];
                end
            end
        end

        assign inst_w[r*3 +: 3] = inst_q;
        assign in_w[r*bw +: bw] = vec_q[bw-1:0];
    end

endmodule

// File: tb/tb_west_edge_feeder.sv
// Testbench for west_edge_feeder. The reference model records what row 0
// should hold each cycle in a time-indexed history. Row r is then that
// history read r cycles back. Command progress is tracked as an
// accept/issue/finish schedule.
module tb_west_edge_feeder;

    localparam int BW  = 4;
    localparam int ROW = 4;
    localparam int LBW = 8;
    localparam int DW  = ROW * BW;
    localparam int NC  = 4096;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic              cmd_os = 1'b0;
    logic [LBW-1:0]    cmd_len = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [DW-1:0]     data_in = '0;
    logic [ROW*3-1:0]  inst_w;
    logic [DW-1:0]     in_w;
    logic              busy;
    logic              done;

    west_edge_feeder #(.bw(BW), .row(ROW), .len_bw(LBW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_os(cmd_os), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .inst_w(inst_w), .in_w(in_w), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    int             t = 0;
    logic [2:0]     h_inst [NC];
    logic [DW-1:0]  h_vec  [NC];
    bit             m_active = 0;
    bit             m_issuing = 0;
    bit             m_os = 0;
    int             m_op = 0, m_len = 0, m_cnt = 0, m_done_cyc = -1;
    int             row_ops [ROW];
    int             last_done_t = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, t);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            h_inst[i] = '0;
            h_vec[i]  = '0;
        end
        m_active = 0; m_issuing = 0; m_os = 0; m_done_cyc = -1;
    endtask

    // One clock cycle: drive inputs after the edge, check mid-cycle, then
    // let the model decide what row 0 holds next cycle.
    task automatic step(input bit cv, input logic [1:0] op, input bit os,
                        input logic [LBW-1:0] len, input bit dv, input logic [DW-1:0] din);
        logic [ROW*3-1:0] ei;
        logic [DW-1:0]    ev;
        logic [2:0]       ni;
        logic [DW-1:0]    nv;
        bit               iss;
        @(posedge clk);
        #1;
        cmd_valid = cv; cmd_op = op; cmd_os = os; cmd_len = len;
        data_valid = dv; data_in = din;
        @(negedge clk);
        ei = '0; ev = '0;
        for (int r = 0; r < ROW; r++) begin
            if (t - r >= 0) begin
                ei[r*3 +: 3]   = h_inst[t-r];
                ev[r*BW +: BW] = h_vec[t-r][r*BW +: BW];
            end
        end
        check_eq("inst_w", inst_w, ei);
        check_eq("in_w", in_w, ev);
        check_eq("cmd_ready", cmd_ready, !m_active);
        check_eq("busy", busy, m_active);
        check_eq("done", done, t == m_done_cyc);
        check_eq("data_ready", data_ready, m_active && m_issuing && m_op != 2 && dv);
        for (int r = 0; r < ROW; r++)
            if (inst_w[r*3 +: 2] != 2'b00) row_ops[r]++;
        if (done === 1'b1) last_done_t = t;

        ni = {m_os, 2'b00};
        nv = '0;
        iss = 0;
        if (!m_active) begin
            if (cv) begin
                m_active = 1; m_op = op; m_os = os; m_len = len; m_cnt = 0;
                ni = {os, 2'b00};
                if (len == 0 || op == 2'b11) begin
                    m_issuing  = 0;
                    m_done_cyc = t + 1;
                end else begin
                    m_issuing = 1;
                end
            end
        end else if (m_issuing) begin
            if (m_op == 2) begin
                ni = {m_os, 2'b01}; iss = 1;
            end else if (dv) begin
                ni = {m_os, m_op == 1, m_op == 0}; nv = din; iss = 1;
            end
            if (iss) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_issuing  = 0;
                    m_done_cyc = t + ROW;
                end
            end
        end else if (t == m_done_cyc) begin
            m_active = 0;
        end
        if (t + 1 >= NC) begin
            $display("FAIL history_overflow got=%0d exp<%0d", t + 1, NC);
            $fatal(1, "history overflow");
        end
        h_inst[t+1] = ni;
        h_vec[t+1]  = nv;
        t++;
    endtask

    // Run one command to completion. gap_at is the cycle (counted from
    // accept) with data_valid low. exp_done_rel < 0 skips the latency check.
    task automatic do_cmd(input logic [1:0] op, input bit os, input int len,
                          input int gap_at, input bit rnd, input int exp_done_rel);
        int  t0;
        int  k;
        bit  dv;
        for (int r = 0; r < ROW; r++) row_ops[r] = 0;
        last_done_t = -1;
        t0 = t;
        step(1'b1, op, os, LBW'(len), 1'b0, DW'($urandom));
        k = 1;
        while (m_active && k < 200) begin
            dv = rnd ? ($urandom_range(0, 3) != 0) : (k != gap_at);
            step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 LBW'($urandom), dv, DW'($urandom));
            k++;
        end
        if (m_active) check_eq("timeout", 1, 0);
        if (exp_done_rel >= 0) check_eq("done_latency", last_done_t - t0, exp_done_rel);
        for (int r = 0; r < ROW; r++)
            check_eq($sformatf("op_count_row%0d", r), row_ops[r],
                     (op != 2'b11 && len > 0) ? len : 0);
        step(1'b0, 2'b00, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        model_clear();
        #12;
        check_eq("rst_inst_w", inst_w, '0);
        check_eq("rst_in_w", in_w, '0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_data_ready", data_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, '0, 1'b1, DW'($urandom));

        // WS LOAD, gapless, len 3.
        do_cmd(2'b00, 1'b0, 3, -1, 1'b0, 3 + ROW);
        // EXEC with one bubble.
        do_cmd(2'b01, 1'b0, 4, 2, 1'b0, 4 + ROW + 1);
        // OS FLUSH, len 2.
        do_cmd(2'b10, 1'b1, 2, -1, 1'b0, 2 + ROW);
        // Degenerate commands.
        do_cmd(2'b01, 1'b1, 0, -1, 1'b0, 1);
        do_cmd(2'b11, 1'b0, 5, -1, 1'b0, 1);

        // Reset in the middle of an EXEC after two vectors.
        step(1'b1, 2'b01, 1'b1, LBW'(5), 1'b0, '0);
        step(1'b0, 2'b00, 1'b0, '0, 1'b1, DW'($urandom));
        step(1'b0, 2'b00, 1'b0, '0, 1'b1, DW'($urandom));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_inst_w", inst_w, '0);
        check_eq("midrst_in_w", in_w, '0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        t++;
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 1'b0, '0, 1'b1, DW'($urandom));
        do_cmd(2'b00, 1'b1, 3, -1, 1'b0, 3 + ROW);

        // Randomized commands with random gaps.
        for (int n = 0; n < 25; n++) begin
            do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6), -1, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/west_edge_feeder.md
# west_edge_feeder

Drives the west edge of the systolic MAC array: for each of `row` rows it produces the 3-bit instruction word and the `bw`-bit activation that the row's first tile consumes on `inst_w` / `in_w`. It accepts one command at a time, streams vectors from an upstream buffer, and applies the one-cycle-per-row skew the array requires. It signals completion once the last row has seen the final operation. It is the issuing end of the tile instruction protocol: bit 2 selects OS, bit 1 is execute, bit 0 is kernel-load (WS) or flush (OS).

## Interface
- `bw`, 4, activation width per row
- `row`, 8, number of array rows (≥1)
- `len_bw`, 8, width of command length field
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `cmd_valid`  input  1  command offered
- `cmd_ready`  output  1  high only in IDLE
- `cmd_op`  input  2  00 LOAD, 01 EXEC, 10 FLUSH, 11 reserved
- `cmd_os`  input  1  OS mode bit for this command
- `cmd_len`  input  len_bw  number of vectors/cycles to issue
- `data_valid`  input  1  upstream vector available
- `data_ready`  output  1  vector consumed this cycle
- `data_in`  input  row*bw  vector; row r in bits [r*bw +: bw]
- `inst_w`  output  row*3  per-row instruction; row r in bits [r*3 +: 3]
- `in_w`  output  row*bw  per-row activation
- `busy`  output  1  high from the cycle after accept through the done cycle
- `done`  output  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch op, os and len, then go to ISSUE.
  - len = 0 or op = 11: no vector issued; `done` pulses in the next cycle, then return to IDLE.
- **ISSUE, LOAD/EXEC**
  - `data_ready` = `data_valid`.
  - Each accepted vector loads row-0 stage: inst = {os, op==EXEC, op==LOAD}, `in_w` = `data_in` slice 0.
  - Upper slices are forwarded through the skew pipeline. Row r's data is delayed r cycles together with its instruction.
  - Cycle with `data_valid` = 0: bubble. Row-0 inst = {os, 0, 0}, `in_w` = 0. Bubbles do not count.
- **ISSUE, FLUSH**
  - `data_ready` = 0.
  - Issue inst {os, 0, 1} with `in_w` = 0 on len consecutive cycles.
- Leaving ISSUE: the issue counter increments per issued vector. At the edge where count reaches len, go to DRAIN.
- **DRAIN**: row-0 stage holds {os, 0, 0}. Wait until row `row`-1 has presented the last op, pulse `done`, return to IDLE.
- Skew rule: row r stage at cycle t equals row r-1 stage at cycle t-1 (inst and data).
- Mode bit: `inst_w[2]` of every row holds the last accepted `cmd_os`, including in IDLE. It propagates with skew. The tiles need a stable OS select between commands.
- `cmd_len` is unsigned. No wrap: the counter is `len_bw` bits and compares for equality.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - all stages, `inst_w`, `in_w`, `busy`, `done`, `data_ready` = 0
  - `cmd_ready` = 1
  - state IDLE, stored os = 0.
- Command accepted at the edge ending cycle 0 → ISSUE in cycle 1.
- Vector k accepted at the edge ending cycle c_k → row r presents it during cycle c_k+1+r.
- Last vector/flush at cycle c → `done` high in cycle c+`row`. `cmd_ready` high from cycle c+`row`+1. No command overlap.
- Gapless stream: len vectors occupy cycles 1..len. `done` in cycle len+`row`.
- `data_ready` is combinational from `data_valid` and state, and never high outside ISSUE.
- Reset asserted mid-command: outputs clear immediately. The partial command is discarded and no `done` is produced.

## Test plan
- Reset check: deassert reset, row=4. Require `cmd_ready`=1, all `inst_w`/`in_w`=0, `done`=0.
- WS LOAD, len=3, data always valid, row=4, vectors V0..V2:
  - row r shows inst 001 with Vk slice r in cycle k+2+r
  - `done` in cycle 3+4=7; `cmd_ready` in cycle 8.
- EXEC, os=0, len=4, `data_valid` low in cycle 2:
  - row 0 shows 000 bubble in cycle 3
  - exactly 4 inst=010 per row, each row delayed one cycle from the row above
  - `done` one cycle later than the gapless case.
- OS FLUSH, len=2:
  - `data_ready` never high
  - each row shows 101 twice with `in_w`=0, then 100 held through IDLE.
- len=0 and op=11:
  - `done` pulses in the cycle after accept
  - no inst bits 1:0 set on any row.
- Reset mid-EXEC (len=5, after 2 vectors):
  - outputs zero immediately, no `done`
  - a fresh LOAD afterwards completes normally.
